tt_um_dsp_fir_top: RTL

//   Tiny Tapeout top-level DSP block: parametrised sequential N-tap signed FIR filter with runtime-loadable coefficients.

---
 rtl/tt_um_dsp_fir_top_if.sv | 30 +++
 rtl/tt_um_dsp_fir_top.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/tt_um_dsp_fir_top_if.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_dsp_fir_top_if
// Brief    : Tiny Tapeout pin bundle for the sequential FIR block
// Revision : 1.0  initial release
// ============================================================================
interface tt_um_dsp_fir_top_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface
`default_nettype wire

// File: rtl/tt_um_dsp_fir_top.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_dsp_fir_top
// Brief    : N-tap signed FIR, one shared MAC, runtime-loadable coefficients
// Revision : 1.0  initial release
// ============================================================================
module tt_um_dsp_fir_top #(
    parameter int TAPS        = 4,
    parameter int COEF_W      = 8,
    parameter int OUT_SHIFT   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    tt_um_dsp_fir_top_if.slave   bus
);

    localparam int c_tap_w  = $clog2(TAPS);
    localparam int c_prod_w = 8 + COEF_W;
    localparam int c_acc_w  = 8 + COEF_W + $clog2(TAPS);
    localparam logic [c_tap_w-1:0]        c_last_tap = c_tap_w'(TAPS - 1);
    localparam logic signed [c_acc_w-1:0] c_sat_max  = c_acc_w'(127);
    localparam logic signed [c_acc_w-1:0] c_sat_min  = -c_acc_w'(128);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0]      r_sync_stb;
    logic [SYNC_STAGES-1:0]      r_sync_mode;
    logic                        r_stb_d;
    logic signed [7:0]           r_x    [TAPS];
    logic signed [COEF_W-1:0]    r_coef [TAPS];
    logic signed [c_acc_w-1:0]   r_acc;
    logic [c_tap_w-1:0]          r_tap;
    logic [7:0]                  r_uo_out;
    logic                        r_ready;
    logic                        r_overrun;

    logic                        w_stb_s;
    logic                        w_mode_s;
    logic                        w_rise;
    logic                        w_busy;
    logic [2:0]                  w_idx;
    logic signed [7:0]           w_x_sel;
    logic signed [COEF_W-1:0]    w_c_sel;
    logic signed [c_prod_w-1:0]  w_prod;
    logic signed [c_acc_w-1:0]   w_shifted;
    logic [7:0]                  w_sat;
    logic                        w_unused_pins;

    assign w_stb_s  = r_sync_stb[SYNC_STAGES-1];
    assign w_mode_s = r_sync_mode[SYNC_STAGES-1];
    // Edge tracking runs even with ena low, so an edge seen then is lost rather than deferred.
    assign w_rise   = ena & w_stb_s & ~r_stb_d;
    assign w_busy   = (r_state != S_IDLE);
    assign w_idx    = bus.uio_in[4:2];

    assign w_x_sel   = r_x[r_tap];
    assign w_c_sel   = r_coef[r_tap];
    assign w_prod    = w_x_sel * w_c_sel;
    assign w_shifted = r_acc >>> OUT_SHIFT;
    assign w_sat     = (w_shifted > c_sat_max) ? 8'h7F :
                       (w_shifted < c_sat_min) ? 8'h80 : w_shifted[7:0];

    assign bus.uo_out  = r_uo_out;
    assign bus.uio_out = {r_ready, r_overrun, w_busy, 5'b0_0000};
    assign bus.uio_oe  = 8'hE0;

    assign w_unused_pins = &{1'b0, bus.uio_in[7:5]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ena) begin
            case (r_state)
                S_IDLE:  if (w_rise && !w_mode_s) w_state_nxt = S_MAC;
                S_MAC:   if (r_tap == c_last_tap) w_state_nxt = S_OUT;
                S_OUT:   w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync_stb  <= '0;
            r_sync_mode <= '0;
            r_stb_d     <= 1'b0;
            r_acc       <= '0;
            r_tap       <= '0;
            r_uo_out    <= 8'h00;
            r_ready     <= 1'b0;
            r_overrun   <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                r_x[i]    <= '0;
                r_coef[i] <= (i == 0) ? COEF_W'(1) : '0;
            end
        end else begin
            r_sync_stb  <= {r_sync_stb[SYNC_STAGES-2:0],  bus.uio_in[0]};
            r_sync_mode <= {r_sync_mode[SYNC_STAGES-2:0], bus.uio_in[1]};
            r_stb_d     <= w_stb_s;
            if (ena) begin
                if (w_rise && w_busy) begin
                    r_overrun <= 1'b1;
                end
                case (r_state)
                    S_IDLE: begin
                        if (w_rise && w_mode_s) begin
                            // Indices at or above TAPS match no slot and are dropped.
                            for (int k = 0; k < TAPS; k++) begin
                                if (w_idx == 3'(k)) r_coef[k] <= bus.ui_in[COEF_W-1:0];
                            end
                        end else if (w_rise) begin
                            for (int i = TAPS - 1; i > 0; i--) begin
                                r_x[i] <= r_x[i-1];
                            end
                            r_x[0]  <= bus.ui_in;
                            r_acc   <= '0;
                            r_tap   <= '0;
                            r_ready <= 1'b0;
                        end
                    end
                    S_MAC: begin
                        r_acc <= r_acc + c_acc_w'(w_prod);
                        r_tap <= (r_tap == c_last_tap) ? '0 : r_tap + 1'b1;
                    end
                    S_OUT: begin
                        r_uo_out <= w_sat;
                        r_ready  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire
